// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx
//  Description : I2S transmitter. Derives BCLK/LRCLK from the system clock,
//                takes one mono 24-bit sample per 64-BCLK frame through a
//                valid/ready handshake and sends it MSB-first in both the
//                left and right slots with the standard one-bit I2S delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int BCLK_HALF = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] sample_in_data,
    input  logic        sample_in_valid,
    output logic        sample_in_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DATA_W = 24;
    localparam int c_DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_MAX   = c_DIV_W'(BCLK_HALF - 1);
    localparam logic [5:0]         c_BIT_LAST  = 6'd63;
    localparam logic [4:0]         c_POS_FIRST = 5'd1;
    localparam logic [4:0]         c_POS_LAST  = 5'd24;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic                r_bclk;
    logic [5:0]          r_bit_cnt;
    logic [c_DATA_W-1:0] r_next;
    logic                r_next_full;
    logic [c_DATA_W-1:0] r_active;
    logic                r_ready;
    logic                r_lrclk;
    logic                r_sdata;
    logic                r_underflow;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                w_div_wrap;
    logic                w_fall_event;
    logic                w_frame_start;
    logic [5:0]          w_bit_cnt_nxt;
    logic                w_accept;
    logic                w_next_full_nxt;
    logic [4:0]          w_slot_pos;
    logic                w_in_word;
    logic [4:0]          w_bit_idx;
    logic                w_slot_bit;

    assign w_div_wrap    = (r_div_cnt == c_DIV_MAX);
    // BCLK is about to go 1 -> 0: this is where all serial outputs advance,
    // keeping them half a bit period away from the codec's sampling edge.
    assign w_fall_event  = w_div_wrap && r_bclk;
    assign w_bit_cnt_nxt = r_bit_cnt + 6'd1;
    assign w_frame_start = w_fall_event && (r_bit_cnt == c_BIT_LAST);
    assign w_accept      = sample_in_valid && r_ready;

    // Slot position of the bit that is about to be driven (new bit count).
    assign w_slot_pos    = w_bit_cnt_nxt[4:0];
    assign w_in_word     = (w_slot_pos >= c_POS_FIRST) && (w_slot_pos <= c_POS_LAST);
    assign w_bit_idx     = c_POS_LAST - w_slot_pos;
    assign w_slot_bit    = w_in_word ? r_active[w_bit_idx] : 1'b0;

    // Occupancy of the holding register after this cycle; a handshake that
    // coincides with a frame start lands in the emptied slot for next frame.
    always_comb begin
        w_next_full_nxt = r_next_full;
        if (w_frame_start) begin
            w_next_full_nxt = 1'b0;
        end
        if (w_accept) begin
            w_next_full_nxt = 1'b1;
        end
    end

    // BCLK divider: half-period counter toggling the bit clock on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Bit position within the 64-bit frame, advanced on each BCLK fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= c_BIT_LAST;
        end else if (w_fall_event) begin
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    // Input holding register and registered ready (= holding register empty).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next      <= '0;
            r_next_full <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_next <= sample_in_data;
            end
            r_next_full <= w_next_full_nxt;
            r_ready     <= ~w_next_full_nxt;
        end
    end

    // Frame-start load of the word being shifted out; silence on underflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active    <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= w_frame_start && !r_next_full;
            if (w_frame_start) begin
                r_active <= r_next_full ? r_next : '0;
            end
        end
    end

    // Serializer: word select and data bit, both updated on BCLK falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
        end else if (w_fall_event) begin
            r_lrclk <= w_bit_cnt_nxt[5];
            r_sdata <= w_slot_bit;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sample_in_ready = r_ready;
    assign bclk            = r_bclk;
    assign lrclk           = r_lrclk;
    assign sdata           = r_sdata;
    assign underflow       = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx
//  Description : Self-checking bench for i2s_tx. Stimulus pushes the expected
//                content of each frame into a queue; a monitor decodes the
//                serial stream on BCLK rises and compares whole frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int c_HALF  = 16;
    localparam int c_FRAME = 128 * c_HALF;

    typedef struct packed {
        logic [23:0] word;
        logic        uf;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] data  = '0;
    logic        valid = 1'b0;
    logic        ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    exp_t exp_q[$];

    int bclk_bad  = 0;
    int bclk_meas = 0;
    int lr_bad    = 0;
    int lr_meas   = 0;
    int stab_bad  = 0;
    int frames_done = 0;

    i2s_tx #(.BCLK_HALF(c_HALF)) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in_data  (data),
        .sample_in_valid (valid),
        .sample_in_ready (ready),
        .bclk            (bclk),
        .lrclk           (lrclk),
        .sdata           (sdata),
        .underflow       (underflow)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic int nstart(input int f);
        return 32 + c_FRAME * f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [23:0] w, input logic uf);
        exp_t e;
        e.word = w;
        e.uf   = uf;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Offer a sample and wait for the handshake; hs = posedge index of it.
    task automatic send(input logic [23:0] d, output int hs);
        int n;
        n     = 0;
        data  = d;
        valid = 1'b1;
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (!ready) begin
            n_fail++;
            $display("FAIL send_timeout: no ready within %0d cycles for %h", n, d);
            hs = -1;
        end else begin
            hs = cyc + 1;
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: decode frames at BCLK rises, measure clock timing
    // ------------------------------------------------------------------------
    initial begin
        int rise_cnt, uf_cnt, p;
        int last_rise, last_chg, last_lr_rise, last_lr_fall;
        logic prev_bclk, prev_lr, prev_sd;
        logic [63:0] lr_bits, sd_bits;
        logic [23:0] lw, rw;
        logic pad_ok, lr_ok;
        exp_t e;
        rise_cnt = 0; uf_cnt = 0; p = 0;
        last_rise = -1; last_chg = -1; last_lr_rise = -1; last_lr_fall = -1;
        prev_bclk = 0; prev_lr = 0; prev_sd = 0;
        lr_bits = '0; sd_bits = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rise_cnt = 0; uf_cnt = 0;
                last_rise = -1; last_chg = -1; last_lr_rise = -1; last_lr_fall = -1;
                prev_bclk = 0; prev_lr = 0; prev_sd = 0;
            end else begin
                if (underflow) uf_cnt++;
                if (lrclk !== prev_lr || sdata !== prev_sd) begin
                    if (last_rise >= 0 && cyc - last_rise <= 1) stab_bad++;
                    last_chg = cyc;
                end
                if (lrclk && !prev_lr) begin
                    if (last_lr_rise >= 0) begin
                        lr_meas++;
                        if (cyc - last_lr_rise != c_FRAME) lr_bad++;
                    end
                    if (last_lr_fall >= 0 && cyc - last_lr_fall != c_FRAME / 2) lr_bad++;
                    last_lr_rise = cyc;
                end
                if (!lrclk && prev_lr) begin
                    if (last_lr_rise >= 0 && cyc - last_lr_rise != c_FRAME / 2) lr_bad++;
                    last_lr_fall = cyc;
                end
                if (bclk && !prev_bclk) begin
                    if (last_rise >= 0) begin
                        bclk_meas++;
                        if (cyc - last_rise != 2 * c_HALF) bclk_bad++;
                    end
                    if (last_chg >= 0 && cyc - last_chg <= 1) stab_bad++;
                    last_rise = cyc;
                    if (rise_cnt >= 1) begin
                        p = (rise_cnt - 1) % 64;
                        lr_bits[p] = lrclk;
                        sd_bits[p] = sdata;
                        if (p == 63) begin
                            lw = '0; rw = '0; pad_ok = 1'b1; lr_ok = 1'b1;
                            for (int i = 0; i < 64; i++) begin
                                if (lr_bits[i] !== (i >= 32)) lr_ok = 1'b0;
                                if ((i % 32) >= 1 && (i % 32) <= 24) begin
                                    if (i < 32) lw = {lw[22:0], sd_bits[i]};
                                    else        rw = {rw[22:0], sd_bits[i]};
                                end else if (sd_bits[i] !== 1'b0) begin
                                    pad_ok = 1'b0;
                                end
                            end
                            if (exp_q.size() == 0) begin
                                n_tests++;
                                n_fail++;
                                $display("FAIL unexpected_frame %0d: left %h right %h", frames_done, lw, rw);
                            end else begin
                                e = exp_q.pop_front();
                                check($sformatf("f%0d_left", frames_done), 32'(lw), 32'(e.word));
                                check($sformatf("f%0d_right", frames_done), 32'(rw), 32'(e.word));
                                check($sformatf("f%0d_padding", frames_done), 32'(pad_ok), 32'd1);
                                check($sformatf("f%0d_lrclk", frames_done), 32'(lr_ok), 32'd1);
                                check($sformatf("f%0d_underflow", frames_done), 32'(uf_cnt), 32'(e.uf));
                            end
                            uf_cnt = 0;
                            frames_done++;
                        end
                    end
                    rise_cnt++;
                end
                prev_lr   = lrclk;
                prev_sd   = sdata;
                prev_bclk = bclk;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic [23:0] words [4];
        int hs [4];
        int hs1;
        words[0] = 24'h800000;
        words[1] = 24'h7FFFFF;
        words[2] = 24'h000001;
        words[3] = 24'h0F0F0F;

        // Reset behaviour and first edges
        repeat (10) begin
            @(negedge clk);
            check("reset_outputs", 32'({ready, bclk, lrclk, sdata, underflow}), 32'd0);
        end
        reset = 1'b0;
        push_exp(24'h0, 1'b1);
        #1 check("ready_before_edge", 32'(ready), 32'd0);
        wait_cyc(1);  check("ready_after_release", 32'(ready), 32'd1);
        wait_cyc(15); check("bclk_c15", 32'(bclk), 32'd0);
        wait_cyc(16); check("bclk_c16", 32'(bclk), 32'd1);
        wait_cyc(31); check("uf_c31", 32'(underflow), 32'd0);
        wait_cyc(32); check("uf_c32", 32'(underflow), 32'd1);
        wait_cyc(33); check("uf_c33", 32'(underflow), 32'd0);

        // Single sample followed by an empty frame
        push_exp(24'hA5C3F0, 1'b0);
        push_exp(24'h0, 1'b1);
        send(24'hA5C3F0, hs1);
        valid = 1'b0;
        check("single_hs_ready_drop", 32'(ready), 32'd0);

        // Continuous stream, one sample per frame
        wait_cyc(nstart(2) + 10);
        for (int i = 0; i < 4; i++) push_exp(words[i], 1'b0);
        push_exp(24'h0, 1'b1);
        for (int i = 0; i < 4; i++) send(words[i], hs[i]);
        valid = 1'b0;
        check("stream_hs1_cycle", 32'(hs[1]), 32'(nstart(3) + 1));
        check("stream_hs_interval2", 32'(hs[2] - hs[1]), 32'(c_FRAME));
        check("stream_hs_interval3", 32'(hs[3] - hs[2]), 32'(c_FRAME));

        // Valid first rises on the frame-start edge itself
        wait_cyc(nstart(8) - 1);
        check("simul_ready", 32'(ready), 32'd1);
        push_exp(24'h0, 1'b1);
        push_exp(24'h123456, 1'b0);
        data  = 24'h123456;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        check("simul_underflow", 32'(underflow), 32'd1);
        check("simul_ready_drop", 32'(ready), 32'd0);

        // Asynchronous reset in the right slot with a sample buffered
        wait_cyc(nstart(10) + 100);
        send(24'hBADCAF, hs1);
        valid = 1'b0;
        check("mid_hs_cycle", 32'(hs1), 32'(nstart(10) + 101));
        wait_cyc(nstart(10) + 40 * 32 + 5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("mid_lrclk_right", 32'(lrclk), 32'd1);
        check("mid_ready_full", 32'(ready), 32'd0);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", 32'({ready, bclk, lrclk, sdata, underflow}), 32'd0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        push_exp(24'h0, 1'b1);
        push_exp(24'h0, 1'b1);
        wait_cyc(nstart(2) + 20);

        // Totals and clock timing
        check("queue_empty_end", 32'(exp_q.size()), 32'd0);
        check("frames_seen", 32'(frames_done), 32'd12);
        check("bclk_period_errors", 32'(bclk_bad), 32'd0);
        check("bclk_measured", 32'(bclk_meas > 100), 32'd1);
        check("lrclk_period_duty_errors", 32'(lr_bad), 32'd0);
        check("lrclk_measured", 32'(lr_meas >= 4), 32'd1);
        check("edge_stability_errors", 32'(stab_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
